// File: rtl/clock_pkg.sv
// clock_pkg: shared setup-sequencer states, field indices and helpers.
package clock_pkg;
  typedef enum logic [2:0] {RUN, S_HOUR, S_MIN, S_DAY, S_MONTH, S_YEAR} state_t;
  localparam int FLD_HOUR = 0;
  localparam int FLD_MIN = 1;
  localparam int FLD_DAY = 2;
  localparam int FLD_MONTH = 3;
  localparam int FLD_YEAR = 4;
  localparam int N_FIELDS = 5;
  localparam int TO_W = 6;
  function automatic state_t next_mode(state_t s);
    return s == S_YEAR ? RUN : state_t'(s + 3'd1);
  endfunction
  // Field index is state - 1, so the selected field's bit is cleared.
  function automatic logic [N_FIELDS-1:0] field_sel_n(state_t s);
    return s == RUN ? '1 : ~(N_FIELDS'(1) << (s - 3'd1));
  endfunction
endpackage

// File: rtl/clock_setup_ctrl_if.sv
// clock_setup_ctrl_if: front-panel inputs and field-counter controls.
interface clock_setup_ctrl_if;
  logic sec_tick, btn_mode, btn_up, btn_down;
  logic display, setup_hour, setup_min, setup_day, setup_month, setup_year;
  logic tick, inc_dec, blink;
  modport master(
    output sec_tick, btn_mode, btn_up, btn_down,
    input display, setup_hour, setup_min, setup_day, setup_month, setup_year, tick, inc_dec, blink
  );
  modport slave(
    input sec_tick, btn_mode, btn_up, btn_down,
    output display, setup_hour, setup_min, setup_day, setup_month, setup_year, tick, inc_dec, blink
  );
endinterface

// File: rtl/btn_repeat.sv
// btn_repeat: press-edge detect plus auto-repeat for one held button.
module btn_repeat #(
  parameter int DELAY = 50_000_000,
  parameter int RATE = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clear,
  output logic tick_pulse
);
  localparam int W = $clog2(DELAY + 1);
  logic prev;
  logic [W-1:0] cnt;
  logic expire;
  assign expire = level && cnt == W'(DELAY);
  assign tick_pulse = ~clear & ((level & ~prev) | expire);
  // After the first expiry, reload so the next one lands RATE cycles later.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= level;
      cnt <= (clear || !level) ? '0 : expire ? W'(DELAY - RATE + 1) : cnt + 1'b1;
    end
endmodule

// File: rtl/clock_setup_ctrl.sv
// clock_setup_ctrl: button-driven setup sequencer with auto-repeat, timeout and blink.
module clock_setup_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000,
  parameter int TIMEOUT_SEC = 30
) (
  input logic clk,
  input logic rst,
  clock_setup_ctrl_if.slave bus
);
  state_t state, state_n;
  logic mode_prev, mode_edge, in_setup, timeout, clr, up_p, dn_p, tick_n;
  logic [TO_W-1:0] to_cnt;
  logic [N_FIELDS-1:0] sel_q;
  assign in_setup = state != RUN;
  assign mode_edge = bus.btn_mode & ~mode_prev;
  assign timeout = in_setup && to_cnt == TO_W'(TIMEOUT_SEC);
  // Mode, timeout and both-held all cancel adjust and restart the repeat delay.
  assign clr = ~in_setup | mode_edge | timeout | (bus.btn_up & bus.btn_down);
  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_up (
    .clk(clk), .rst(rst), .level(bus.btn_up), .clear(clr), .tick_pulse(up_p)
  );
  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_dn (
    .clk(clk), .rst(rst), .level(bus.btn_down), .clear(clr), .tick_pulse(dn_p)
  );
  always_comb begin
    state_n = timeout ? RUN : mode_edge ? next_mode(state) : state;
    tick_n = up_p | dn_p;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      mode_prev <= 1'b0;
      to_cnt <= '0;
      sel_q <= '1;
      bus.display <= 1'b0;
      bus.tick <= 1'b0;
      bus.inc_dec <= 1'b1;
      bus.blink <= 1'b0;
    end else begin
      state <= state_n;
      mode_prev <= bus.btn_mode;
      to_cnt <= (!in_setup || timeout || bus.btn_mode || bus.btn_up || bus.btn_down) ? '0
              : to_cnt + TO_W'(bus.sec_tick);
      sel_q <= field_sel_n(state_n);
      bus.display <= state_n != RUN;
      bus.tick <= tick_n;
      bus.inc_dec <= tick_n ? up_p : bus.inc_dec;
      bus.blink <= state_n == RUN ? 1'b0 : tick_n ? 1'b1 : bus.blink ^ bus.sec_tick;
    end
  assign bus.setup_hour = sel_q[FLD_HOUR];
  assign bus.setup_min = sel_q[FLD_MIN];
  assign bus.setup_day = sel_q[FLD_DAY];
  assign bus.setup_month = sel_q[FLD_MONTH];
  assign bus.setup_year = sel_q[FLD_YEAR];
endmodule

// File: tb/tb_clock_setup_ctrl.sv
// tb_clock_setup_ctrl: directed and random checks against a schedule-based reference model.
module tb_clock_setup_ctrl;
  localparam int RD = 8;
  localparam int RR = 4;
  localparam int TO_S = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int md, k, idle;
  bit pm, pu, pd, bl, inc, tk;
  clock_setup_ctrl_if bus();
  clock_setup_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_SEC(TO_S)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus.display, bus.setup_hour, bus.setup_min, bus.setup_day, bus.setup_month,
            bus.setup_year, bus.tick, bus.inc_dec, bus.blink};
  endfunction
  function automatic logic [8:0] exp_o();
    return {md != 0, md != 1, md != 2, md != 3, md != 4, md != 5, tk, inc, bl};
  endfunction

  task automatic model_reset();
    md = 0; k = -1; idle = 0; pm = 0; pu = 0; pd = 0; bl = 0; inc = 1; tk = 0;
  endtask

  // k = cycles since the current single-button hold window began (-1: none).
  task automatic model_step(input bit m, u, d, s);
    bit to, me, ue, de, blk, tc;
    int nm;
    to = md != 0 && idle == TO_S;
    me = m && !pm; ue = u && !pu; de = d && !pd;
    blk = md == 0 || me || to || (u && d);
    if (blk || !(u ^ d)) k = -1;
    else if (ue || de) k = 0;
    else k++;
    tc = k >= 0 && ((k == 0 && (ue || de)) || (k >= RD && (k - RD) % RR == 0));
    nm = to ? 0 : me ? (md + 1) % 6 : md;
    idle = (md == 0 || to || m || u || d) ? 0 : idle + int'(s);
    bl = nm == 0 ? 1'b0 : tc ? 1'b1 : bl ^ s;
    if (tc) inc = u;
    tk = tc; md = nm; pm = m; pu = u; pd = d;
  endtask

  task automatic cyc(input bit m, u, d, s);
    bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.sec_tick = s;
    @(posedge clk);
    model_step(m, u, d, s);
    #1;
  endtask

  task automatic test_reset();
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.sec_tick = 0;
    model_reset();
    #12;
    checks++;
    if (obs() !== 9'b011111010) begin errors++; $display("FAIL reset: got %b want %b", obs(), 9'b011111010); end
    rst = 1'b1;
  endtask

  task automatic test_mode_cycle();
    logic [4:0] tbl [6] = '{5'b01111, 5'b10111, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (obs()[8:3] !== {i != 5, tbl[i]}) begin
        errors++; $display("FAIL mode_cycle[%0d]: got %b want %b", i, obs()[8:3], {i != 5, tbl[i]});
      end
      checks++;
      if (obs() !== exp_o()) begin errors++; $display("FAIL mode_model[%0d]: got %b want %b", i, obs(), exp_o()); end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_repeat();
    logic want;
    repeat (3) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    for (int c = 0; c < 20; c++) begin
      cyc(0, 1, 0, 0);
      want = c == 0 || c == 8 || c == 12 || c == 16;
      checks++;
      if (bus.tick !== want || (want && bus.inc_dec !== 1'b1) || bus.setup_day !== 1'b0) begin
        errors++; $display("FAIL repeat[%0d]: tick %b inc %b day %b want tick %b", c, bus.tick, bus.inc_dec, bus.setup_day, want);
      end
      checks++;
      if (obs() !== exp_o()) begin errors++; $display("FAIL repeat_model[%0d]: got %b want %b", c, obs(), exp_o()); end
    end
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.tick !== 1'b0) begin errors++; $display("FAIL repeat_release[%0d]: tick %b want 0", c, bus.tick); end
    end
  endtask

  task automatic test_both();
    logic want;
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      cyc(0, 1, 1, 0);
      checks++;
      if (bus.tick !== 1'b0 || bus.setup_month !== 1'b0) begin
        errors++; $display("FAIL both[%0d]: tick %b month %b want 0 0", c, bus.tick, bus.setup_month);
      end
    end
    for (int j = 0; j < 10; j++) begin
      cyc(0, 0, 1, 0);
      want = j == 8;
      checks++;
      if (bus.tick !== want || (want && bus.inc_dec !== 1'b0)) begin
        errors++; $display("FAIL down_after_both[%0d]: tick %b inc %b want tick %b inc 0", j, bus.tick, bus.inc_dec, want);
      end
      checks++;
      if (obs() !== exp_o()) begin errors++; $display("FAIL both_model[%0d]: got %b want %b", j, obs(), exp_o()); end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    logic [3:0] stim [12] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000,
                              4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic [3:0] v;
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      v = stim[i];
      cyc(v[3], v[2], v[1], v[0]);
      checks++;
      if (bus.display !== (i != 11)) begin
        errors++; $display("FAIL timeout[%0d]: display %b want %b", i, bus.display, i != 11);
      end
      checks++;
      if (obs() !== exp_o()) begin errors++; $display("FAIL timeout_model[%0d]: got %b want %b", i, obs(), exp_o()); end
    end
    checks++;
    if (obs()[7:3] !== 5'b11111) begin errors++; $display("FAIL timeout_sel: got %b want 11111", obs()[7:3]); end
  endtask

  task automatic test_mode_wins();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++;
    if (bus.tick !== 1'b0 || bus.setup_min !== 1'b0) begin
      errors++; $display("FAIL mode_wins: tick %b min %b want 0 0", bus.tick, bus.setup_min);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.tick !== 1'b0) begin errors++; $display("FAIL mode_wins_after: tick %b want 0", bus.tick); end
    cyc(0, 1, 0, 0);
    checks++;
    if (bus.tick !== 1'b1 || bus.inc_dec !== 1'b1 || bus.setup_min !== 1'b0 || bus.setup_hour !== 1'b1) begin
      errors++; $display("FAIL mode_wins_next: got %b want tick 1 inc 1 min 0", obs());
    end
    checks++;
    if (obs() !== exp_o()) begin errors++; $display("FAIL mode_wins_model: got %b want %b", obs(), exp_o()); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 9'b011111010) begin errors++; $display("FAIL async_reset: got %b want %b", obs(), 9'b011111010); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 9'b011111010) begin errors++; $display("FAIL async_reset_hold: got %b want %b", obs(), 9'b011111010); end
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(0, 1, 0, 0);
      checks++;
      if (bus.tick !== 1'b0 || bus.display !== 1'b0 || obs() !== exp_o()) begin
        errors++; $display("FAIL post_reset[%0d]: got %b want %b", c, obs(), exp_o());
      end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit rm = 0, ru = 0, rdn = 0, rs;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      if ($urandom_range(0, 5) == 0) ru = ~ru;
      if ($urandom_range(0, 5) == 0) rdn = ~rdn;
      rs = $urandom_range(0, 7) == 0;
      cyc(rm, ru, rdn, rs);
      checks++;
      if (obs() !== exp_o()) begin errors++; $display("FAIL random[%0d]: got %b want %b", i, obs(), exp_o()); end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_repeat();
    test_both();
    test_timeout();
    test_mode_wins();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_setup_ctrl.md
Name: clock_setup_ctrl

Overview:
- Front-panel setup sequencer for the calendar clock.
- Turns three debounced button levels into the control signals consumed by the field counters (hour/minute/day/month/year): display, per-field active-low setup selects, a single-cycle tick and an inc_dec direction.
- Adds auto-repeat on held buttons, an inactivity timeout back to run mode, and a blink enable for the selected field.

Parameters:
- REPEAT_DELAY, 50_000_000: clk cycles a button must be held before auto-repeat starts.
- REPEAT_RATE, 10_000_000: clk cycles between auto-repeat ticks.
- TIMEOUT_SEC, 30: sec_tick pulses with no button activity before forced return to RUN; valid range 1..63.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse, once per second.
- btn_mode  in  1  debounced level, 1 = pressed.
- btn_up  in  1  debounced level, 1 = pressed.
- btn_down  in  1  debounced level, 1 = pressed.
- display  out  1  0 = run (counters advance on carries), 1 = setup mode.
- setup_hour  out  1  active-low select for the hour field.
- setup_min  out  1  active-low select for the minute field.
- setup_day  out  1  active-low select for the day field.
- setup_month  out  1  active-low select for the month field.
- setup_year  out  1  active-low select for the year field.
- tick  out  1  one-cycle adjust strobe.
- inc_dec  out  1  1 = increment, 0 = decrement; valid whenever tick=1.
- blink  out  1  blink enable for the selected field.

Behaviour:
- Reset (rst=0, async): state RUN, display=0, all setup_* =1, tick=0, inc_dec=1, blink=0, all counters 0, edge-detect registers 0.
- All outputs are registered. Response latency is 1 clk from the sampled input edge.
- Press edges are detected internally as previous-cycle level 0 and current-cycle level 1.
- FSM states: RUN, S_HOUR, S_MIN, S_DAY, S_MONTH, S_YEAR.
  - A mode press advances the state: RUN->S_HOUR->S_MIN->S_DAY->S_MONTH->S_YEAR->RUN.
- display=1 in every state except RUN.
- Exactly one setup_* is 0, and only in the matching S_* state; all are 1 in RUN.
- RUN: up/down are ignored, tick stays 0, and the repeat and timeout counters are held at 0.
- Adjust in any S_* state:
  - An up press edge gives tick=1 and inc_dec=1 for one cycle.
  - A down press edge gives tick=1 and inc_dec=0.
- Auto-repeat:
  - While exactly one of up/down stays held, rpt_cnt counts clk cycles.
  - On reaching REPEAT_DELAY it emits a tick, then one tick every REPEAT_RATE cycles.
  - rpt_cnt width is $clog2(REPEAT_DELAY+1) and it saturates, never wraps.
  - Release clears rpt_cnt.
- Up and down both high: no tick, rpt_cnt cleared, inc_dec holds its last value.
  - Releasing one of them does not create a new edge; the remaining held button restarts its repeat delay from 0.
- Mode press in the same cycle as an up/down edge or repeat expiry:
  - The mode press wins: state advances, no tick, rpt_cnt cleared.
  - Any later tick goes to the new field only.
- Timeout:
  - In S_*, to_cnt (6 bits) increments on each sec_tick.
  - Any press edge (mode, up or down), or any held button, clears to_cnt.
  - When to_cnt reaches TIMEOUT_SEC, the next cycle forces RUN, display=0 and all setup_* =1.
  - A tick pending in that cycle is suppressed.
- blink:
  - Toggles on each sec_tick while in S_*.
  - Forced to 1 on any tick so the field is visible while adjusting.
  - Forced to 0 in RUN.
- Mode transitions do not go through tick. Field counters are expected to clamp out-of-range values; this block carries no calendar knowledge.
- Reset asserted mid-repeat or mid-setup: immediate return to the reset values, with no trailing tick after release.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum (RUN, S_HOUR, S_MIN, S_DAY, S_MONTH, S_YEAR), reused by the display mux;
  - the field index constants;
  - the TIMEOUT_SEC width constant (6).
- One natural sub-module: btn_repeat.
  - Handles the edge detect and repeat counter for a single button: level in, tick_pulse out, clear in.
  - Instantiated twice, for up and for down. The FSM top combines the two pulses and resolves conflicts.

Test Plan:
- Reset, then 4 mode presses -> display=1 with setup_hour=0, then setup_min=0, setup_day=0, setup_month=0; the 5th press gives setup_year=0; the 6th gives display=0 and all setup_*=1.
- In S_DAY, with REPEAT_DELAY=8 and REPEAT_RATE=4 (bench override), hold btn_up for 20 cycles -> ticks at cycles 1, 9, 13 and 17, all with inc_dec=1; no tick after release.
- In S_MONTH, btn_up and btn_down both high for 10 cycles -> no tick; drop btn_up and keep btn_down -> first repeat tick after 8 cycles, with inc_dec=0.
- With TIMEOUT_SEC=3, enter S_YEAR and send 3 sec_tick with no buttons -> display=0 one cycle after the 3rd; a press between pulses restarts the count.
- Mode edge and up edge in the same cycle while in S_HOUR -> state S_MIN and tick=0; the next up press ticks with setup_min=0.
- Assert rst=0 asynchronously during auto-repeat in S_DAY -> outputs return to reset values immediately; after rst=1 the state is RUN and there is no tick.
